// File: rtl/spi_slave.sv
// SPI target peripheral with a PBUS register file and TX/RX byte FIFOs.
// Define SPI_SLAVE_IRQ_EN to add the irq_o output and the CTRL[6:4] interrupt enables.

module wbit_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

module spi_slave #(
    parameter int XLEN        = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            stb_i,
    input  logic [1:0]      adr_i,
    input  logic [3:0]      byte_sel_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] dat_i,
    output logic [XLEN-1:0] dat_o,
    input  logic            spi_sck_i,
    input  logic            spi_cs_n_i,
    input  logic            spi_mosi_i,
    output logic            spi_miso_o,
    output logic            spi_miso_oe_o
`ifdef SPI_SLAVE_IRQ_EN
    ,
    output logic            irq_o
`endif
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state_q, state_d;
    logic       en_q, cpol_q, cpha_q;
    logic       rx_ovf_q;
    logic [2:0] ie;
    logic [2:0] sync_pipe [SYNC_STAGES];  // {mosi, cs_n, sck} per stage
    logic       sck_s, cs_s, mosi_s;
    logic       sck_prev, cs_prev;
    logic       lead_edge, trail_edge, sample_edge, shift_edge, cs_fall;
    logic       select, run, load, advance;
    logic [2:0] bit_cnt;
    logic       first_q;
    logic [7:0] tx_shift, shift_in, load_byte;
    logic       miso_q;
    logic       byte_done_q;

    logic       wr_en, rd_en, ctrl_wr, tx_push, rx_pop, tx_pop;
    logic [7:0] tx_head, rx_head;
    logic       tx_empty, tx_full, rx_empty, rx_full;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_pipe[i] <= 3'b010;
            sck_prev <= 1'b0;
            cs_prev  <= 1'b1;
        end else begin
            sync_pipe[0] <= {spi_mosi_i, spi_cs_n_i, spi_sck_i};
            for (int i = 1; i < SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
            sck_prev <= sck_s;
            cs_prev  <= cs_s;
        end
    end

    assign sck_s  = sync_pipe[SYNC_STAGES-1][0];
    assign cs_s   = sync_pipe[SYNC_STAGES-1][1];
    assign mosi_s = sync_pipe[SYNC_STAGES-1][2];

    assign lead_edge   = (sck_prev == cpol_q) && (sck_s != cpol_q);
    assign trail_edge  = (sck_prev != cpol_q) && (sck_s == cpol_q);
    assign sample_edge = cpha_q ? trail_edge : lead_edge;
    assign shift_edge  = cpha_q ? lead_edge : trail_edge;
    assign cs_fall     = cs_prev & ~cs_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        case (state_q)
            IDLE:    if (cs_fall && en_q) state_d = ACTIVE;
            ACTIVE:  if (cs_s || !en_q)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        select = (state_q == IDLE) && (state_d == ACTIVE);
        run    = (state_q == ACTIVE) && (state_d == ACTIVE);
        // With cpha=1 the byte loaded at selection is driven by the first leading edge.
        if (select) begin
            load = 1'b1;
        end else if (run && shift_edge && !(cpha_q && first_q)) begin
            if (bit_cnt == 3'd0) load    = 1'b1;
            else                 advance = 1'b1;
        end
    end

    assign load_byte = tx_empty ? 8'hFF : tx_head;
    assign tx_pop    = load & ~tx_empty;

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bit_cnt     <= 3'd0;
            first_q     <= 1'b0;
            tx_shift    <= 8'h00;
            shift_in    <= 8'h00;
            miso_q      <= 1'b0;
            byte_done_q <= 1'b0;
        end else begin
            byte_done_q <= 1'b0;
            if (select) begin
                bit_cnt <= 3'd0;
                first_q <= 1'b1;
            end
            if (run && shift_edge) first_q <= 1'b0;
            if (load) begin
                tx_shift <= load_byte;
                miso_q   <= load_byte[7];
            end else if (advance) begin
                tx_shift <= {tx_shift[6:0], 1'b0};
                miso_q   <= tx_shift[6];
            end else if (state_q == ACTIVE && state_d == IDLE) begin
                miso_q   <= 1'b0;
            end
            if (run && sample_edge) begin
                shift_in    <= {shift_in[6:0], mosi_s};
                bit_cnt     <= bit_cnt + 3'd1;
                byte_done_q <= (bit_cnt == 3'd7);
            end
        end
    end

    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = (state_q == ACTIVE);

    assign wr_en   = stb_i & we_i & byte_sel_i[0];
    assign rd_en   = stb_i & ~we_i & byte_sel_i[0];
    assign ctrl_wr = wr_en && (adr_i == 2'd0);
    assign rx_pop  = rd_en && (adr_i == 2'd2);
    assign tx_push = wr_en && (adr_i == 2'd3);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            en_q     <= 1'b0;
            cpha_q   <= 1'b0;
            cpol_q   <= 1'b0;
            rx_ovf_q <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                en_q   <= dat_i[0];
                cpha_q <= dat_i[2];
                cpol_q <= dat_i[3];
            end
            // A byte dropped in the same cycle as a clear still leaves the flag set.
            if (byte_done_q && rx_full && !rx_pop) rx_ovf_q <= 1'b1;
            else if (ctrl_wr && dat_i[1])          rx_ovf_q <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_IRQ_EN
    logic [2:0] ie_q;
    logic       unused_bits;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ie_q  <= 3'b000;
            irq_o <= 1'b0;
        end else begin
            if (ctrl_wr) ie_q <= dat_i[6:4];
            irq_o <= (ie_q[0] & ~rx_empty) | (ie_q[1] & tx_empty) | (ie_q[2] & rx_ovf_q);
        end
    end

    assign ie          = ie_q;
    assign unused_bits = ^{dat_i[XLEN-1:7], byte_sel_i[3:1]};
`else
    logic unused_bits;

    assign ie          = 3'b000;
    assign unused_bits = ^{dat_i[XLEN-1:4], byte_sel_i[3:1]};
`endif

    always_comb begin
        dat_o = '0;
        case (adr_i)
            2'd0:    dat_o[6:0] = {ie, cpol_q, cpha_q, 1'b0, en_q};
            2'd1:    dat_o[5:0] = {(state_q == ACTIVE), rx_ovf_q, tx_empty, tx_full, rx_empty, rx_full};
            2'd2:    dat_o[7:0] = rx_head;
            default: dat_o      = '0;
        endcase
    end

    wbit_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (tx_push),
        .wdata  (dat_i[7:0]),
        .pop    (tx_pop),
        .rdata  (tx_head),
        .empty  (tx_empty),
        .full   (tx_full)
    );

    wbit_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (byte_done_q),
        .wdata  (shift_in),
        .pop    (rx_pop),
        .rdata  (rx_head),
        .empty  (rx_empty),
        .full   (rx_full)
    );
endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-level SPI master plus a queue-based
// model of the TX/RX FIFOs and the bytes each side must see.
`timescale 1ns/1ps

module tb_spi_slave;
    localparam int XLEN  = 32;
    localparam int DEPTH = 8;
    localparam int HALF  = 4;  // clk cycles per sck half-period (sck = clk/8)

    logic            clk_i = 1'b0;
    logic            rst_ni;
    logic            stb_i;
    logic [1:0]      adr_i;
    logic [3:0]      byte_sel_i;
    logic            we_i;
    logic [XLEN-1:0] dat_i;
    logic [XLEN-1:0] dat_o;
    logic            spi_sck_i;
    logic            spi_cs_n_i;
    logic            spi_mosi_i;
    logic            spi_miso_o;
    logic            spi_miso_oe_o;
`ifdef SPI_SLAVE_IRQ_EN
    logic            irq_o;
`endif

    spi_slave #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .stb_i         (stb_i),
        .adr_i         (adr_i),
        .byte_sel_i    (byte_sel_i),
        .we_i          (we_i),
        .dat_i         (dat_i),
        .dat_o         (dat_o),
        .spi_sck_i     (spi_sck_i),
        .spi_cs_n_i    (spi_cs_n_i),
        .spi_mosi_i    (spi_mosi_i),
        .spi_miso_o    (spi_miso_o),
        .spi_miso_oe_o (spi_miso_oe_o)
`ifdef SPI_SLAVE_IRQ_EN
        ,
        .irq_o         (irq_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    bit         ovf_m;
    bit         cpol_m, cpha_m;
    logic [7:0] mo_buf [16];

    function automatic logic [7:0] exp_status(input bit busy);
        return {2'b00, busy, ovf_m, tx_q.size() == 0, tx_q.size() == DEPTH,
                rx_q.size() == 0, rx_q.size() == DEPTH};
    endfunction

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk_i);
        stb_i = 1'b1; we_i = 1'b1; adr_i = a; dat_i = d;
        @(negedge clk_i);
        stb_i = 1'b0; we_i = 1'b0; adr_i = 2'd1; dat_i = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk_i);
        stb_i = 1'b1; we_i = 1'b0; adr_i = a;
        #1 d = dat_o;
        @(negedge clk_i);
        stb_i = 1'b0; adr_i = 2'd1;
    endtask

    // STATUS is combinational from adr_i, parked at 1 while the bus is idle.
    task automatic peek_status(output logic [7:0] s);
        #1 s = dat_o[7:0];
    endtask

    task automatic write_tx(input logic [7:0] b);
        bus_write(2'd3, {24'h0, b});
        if (tx_q.size() < DEPTH) tx_q.push_back(b);
    endtask

    task automatic set_mode(input bit cpol, input bit cpha);
        cpol_m = cpol;
        cpha_m = cpha;
        spi_sck_i = cpol;
        bus_write(2'd0, {28'h0, cpol, cpha, 2'b01});
        repeat (6) @(negedge clk_i);
    endtask

    task automatic apply_reset();
        rst_ni = 1'b0;
        stb_i = 1'b0; we_i = 1'b0; adr_i = 2'd1; byte_sel_i = 4'hF; dat_i = '0;
        spi_cs_n_i = 1'b1; spi_sck_i = 1'b0; spi_mosi_i = 1'b0;
        cpol_m = 1'b0; cpha_m = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        tx_q.delete();
        rx_q.delete();
        ovf_m = 1'b0;
        repeat (2) @(negedge clk_i);
    endtask

    task automatic select_slave();
        spi_cs_n_i = 1'b0;
        repeat (2 * HALF) @(negedge clk_i);
    endtask

    task automatic deselect_slave();
        repeat (HALF) @(negedge clk_i);
        spi_cs_n_i = 1'b1;
        repeat (2 * HALF) @(negedge clk_i);
    endtask

    // Master side of one byte (or its first nbits), MSB first.
    task automatic xfer_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!cpha_m) begin
                spi_mosi_i = mo[i];
                repeat (HALF) @(negedge clk_i);
                mi[i] = spi_miso_o;
                spi_sck_i = ~cpol_m;
                repeat (HALF) @(negedge clk_i);
                spi_sck_i = cpol_m;
            end else begin
                spi_sck_i = ~cpol_m;
                spi_mosi_i = mo[i];
                repeat (HALF) @(negedge clk_i);
                mi[i] = spi_miso_o;
                spi_sck_i = cpol_m;
                repeat (HALF) @(negedge clk_i);
            end
        end
    endtask

    // One selected frame of n bytes from mo_buf; checks what the master receives.
    task automatic run_frame(input int n);
        logic [7:0] mi, expv, s;
        select_slave();
        n_total++;
        if (spi_miso_oe_o !== 1'b1) $display("FAIL oe_active: got %b expected 1", spi_miso_oe_o);
        else n_pass++;
        peek_status(s);
        n_total++;
        if (s[5] !== 1'b1) $display("FAIL busy_active: got %b expected 1", s[5]);
        else n_pass++;
        for (int k = 0; k < n; k++) begin
            xfer_bits(mo_buf[k], 8, mi);
            if (tx_q.size() != 0) expv = tx_q.pop_front();
            else expv = 8'hFF;
            n_total++;
            if (mi !== expv) $display("FAIL miso_byte[%0d]: got %h expected %h", k, mi, expv);
            else n_pass++;
            if (rx_q.size() < DEPTH) rx_q.push_back(mo_buf[k]);
            else ovf_m = 1'b1;
        end
        // cpha=0 reloads on the trailing edge after every byte, including the last.
        if (!cpha_m && tx_q.size() != 0) void'(tx_q.pop_front());
        deselect_slave();
    endtask

    task automatic drain_rx();
        logic [31:0] d;
        logic [7:0]  expv, s;
        while (rx_q.size() != 0) begin
            expv = rx_q.pop_front();
            bus_read(2'd2, d);
            n_total++;
            if (d[7:0] !== expv) $display("FAIL rdata: got %h expected %h", d[7:0], expv);
            else n_pass++;
        end
        peek_status(s);
        n_total++;
        if (s !== exp_status(1'b0)) $display("FAIL status_drained: got %h expected %h", s, exp_status(1'b0));
        else n_pass++;
    endtask

    task automatic test_reset();
        logic [7:0]  s;
        logic [31:0] d;
        apply_reset();
        n_total++;
        if ({spi_miso_o, spi_miso_oe_o} !== 2'b00)
            $display("FAIL reset_pins: got %b expected 00", {spi_miso_o, spi_miso_oe_o});
        else n_pass++;
        peek_status(s);
        n_total++;
        if (s !== exp_status(1'b0)) $display("FAIL reset_status: got %h expected %h", s, exp_status(1'b0));
        else n_pass++;
        bus_read(2'd0, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL reset_ctrl: got %h expected 0", d);
        else n_pass++;
    endtask

    task automatic test_mode0();
        logic [7:0] s;
        apply_reset();
        set_mode(1'b0, 1'b0);
        write_tx(8'hA5);
        mo_buf[0] = 8'h3C;
        run_frame(1);
        peek_status(s);
        n_total++;
        if (s !== exp_status(1'b0) || s[1] !== 1'b0)
            $display("FAIL mode0_status: got %h expected %h", s, exp_status(1'b0));
        else n_pass++;
        drain_rx();
    endtask

    task automatic test_modes();
        for (int m = 1; m < 4; m++) begin
            apply_reset();
            set_mode(m[1], m[0]);
            write_tx(8'h81);
            write_tx(8'h7E);
            mo_buf[0] = 8'h01;
            mo_buf[1] = 8'hFE;
            run_frame(2);
            drain_rx();
        end
    endtask

    task automatic test_tx_empty();
        apply_reset();
        set_mode(1'b0, 1'b0);
        mo_buf[0] = 8'h55;
        run_frame(1);
        drain_rx();
    endtask

    task automatic test_overflow();
        logic [7:0]  s;
        logic [31:0] d;
        apply_reset();
        set_mode(1'b0, 1'b0);
        for (int k = 0; k < 9; k++) mo_buf[k] = 8'(k);
        run_frame(9);
        peek_status(s);
        n_total++;
        if (s !== exp_status(1'b0) || s[4] !== 1'b1)
            $display("FAIL ovf_status: got %h expected %h", s, exp_status(1'b0));
        else n_pass++;
        drain_rx();
        bus_read(2'd2, d);  // RX empty: no pop, status unchanged
        peek_status(s);
        n_total++;
        if (s !== exp_status(1'b0)) $display("FAIL empty_read_status: got %h expected %h", s, exp_status(1'b0));
        else n_pass++;
        bus_write(2'd0, 32'h0000_0003);
        ovf_m = 1'b0;
        peek_status(s);
        n_total++;
        if (s !== exp_status(1'b0) || s[4] !== 1'b0)
            $display("FAIL ovf_clear: got %h expected %h", s, exp_status(1'b0));
        else n_pass++;
    endtask

    task automatic test_tx_full();
        logic [7:0] s;
        apply_reset();
        set_mode(1'b0, 1'b1);
        for (int k = 0; k < 9; k++) write_tx(8'h10 + 8'(k));
        peek_status(s);
        n_total++;
        if (s !== exp_status(1'b0) || s[2] !== 1'b1)
            $display("FAIL tx_full_status: got %h expected %h", s, exp_status(1'b0));
        else n_pass++;
        mo_buf[0] = 8'hE1;
        mo_buf[1] = 8'h1E;
        run_frame(2);
        drain_rx();
    endtask

    task automatic test_partial();
        logic [7:0] s, mi;
        apply_reset();
        set_mode(1'b0, 1'b0);
        select_slave();
        peek_status(s);
        n_total++;
        if (s[5] !== 1'b1) $display("FAIL partial_busy: got %b expected 1", s[5]);
        else n_pass++;
        xfer_bits(8'hAA, 4, mi);
        deselect_slave();
        peek_status(s);
        n_total++;
        if (s !== exp_status(1'b0)) $display("FAIL partial_idle: got %h expected %h", s, exp_status(1'b0));
        else n_pass++;
        mo_buf[0] = 8'hC3;
        run_frame(1);
        drain_rx();
    endtask

    task automatic test_random();
        int n, ntx;
        for (int it = 0; it < 6; it++) begin
            set_mode(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            ntx = $urandom_range(0, 5);
            for (int k = 0; k < ntx; k++) write_tx(8'($urandom));
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) mo_buf[k] = 8'($urandom);
            run_frame(n);
            drain_rx();
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0]  s, mi;
        logic [31:0] d;
        apply_reset();
        set_mode(1'b0, 1'b0);
        write_tx(8'h5A);
        select_slave();
        xfer_bits(8'h96, 3, mi);
        repeat (HALF) @(negedge clk_i);
        n_total++;
        if (spi_miso_o !== 1'b1) $display("FAIL mid_miso: got %b expected 1", spi_miso_o);
        else n_pass++;
        rst_ni = 1'b0;
        #1;
        n_total++;
        if ({spi_miso_o, spi_miso_oe_o} !== 2'b00)
            $display("FAIL mid_reset_pins: got %b expected 00", {spi_miso_o, spi_miso_oe_o});
        else n_pass++;
`ifdef SPI_SLAVE_IRQ_EN
        n_total++;
        if (irq_o !== 1'b0) $display("FAIL mid_reset_irq: got %b expected 0", irq_o);
        else n_pass++;
`endif
        tx_q.delete();
        rx_q.delete();
        ovf_m = 1'b0;
        peek_status(s);
        n_total++;
        if (s !== exp_status(1'b0)) $display("FAIL mid_reset_status: got %h expected %h", s, exp_status(1'b0));
        else n_pass++;
        spi_cs_n_i = 1'b1;
        spi_sck_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        bus_read(2'd0, d);
        n_total++;
        if (d !== 32'h0) $display("FAIL mid_reset_ctrl: got %h expected 0", d);
        else n_pass++;
    endtask

`ifdef SPI_SLAVE_IRQ_EN
    task automatic test_irq();
        logic [31:0] d;
        apply_reset();
        spi_sck_i = 1'b0;
        bus_write(2'd0, 32'h0000_0011);
        repeat (3) @(negedge clk_i);
        n_total++;
        if (irq_o !== 1'b0) $display("FAIL irq_idle: got %b expected 0", irq_o);
        else n_pass++;
        mo_buf[0] = 8'h99;
        run_frame(1);
        n_total++;
        if (irq_o !== 1'b1) $display("FAIL irq_rxne: got %b expected 1", irq_o);
        else n_pass++;
        bus_read(2'd2, d);
        void'(rx_q.pop_front());
        n_total++;
        if (d[7:0] !== 8'h99 || irq_o !== 1'b1)
            $display("FAIL irq_pop_cycle: got %h/%b expected 99/1", d[7:0], irq_o);
        else n_pass++;
        @(negedge clk_i);
        n_total++;
        if (irq_o !== 1'b0) $display("FAIL irq_cleared: got %b expected 0", irq_o);
        else n_pass++;
    endtask
`endif

    initial begin
        #500us;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        test_reset();
        test_mode0();
        test_modes();
        test_tx_empty();
        test_overflow();
        test_tx_full();
        test_partial();
        test_random();
`ifdef SPI_SLAVE_IRQ_EN
        test_irq();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
